input_conditioner: RTL

//   Sits between the raw DE1-SoC push-buttons and the character fsm / step-clock logic.

---
 rtl/input_conditioner.sv | 131 +++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Push-button front end: 2-flop sync, per-key debounce, press edge detect and
// frame-aligned capture so game logic sees stable per-frame key state.

module input_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  input  logic frame_tick,
  output logic key_level,
  output logic key_press,
  output logic frame_level,
  output logic frame_press
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             pending_q, pending_d;
  logic             flevel_q, flevel_d;
  logic             fpress_q, fpress_d;
  logic             press;

  assign press = level_q & ~level_dly_q;

  always_comb begin
    sync1_d     = ~key_n;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    // Any return to the accepted level restarts the count, so glitches never land.
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    flevel_d  = flevel_q;
    fpress_d  = fpress_q;
    // A press landing on the tick belongs to the frame that is closing.
    if (frame_tick) begin
      flevel_d  = level_q;
      fpress_d  = pending_q | press;
      pending_d = 1'b0;
    end else if (press) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pending_q   <= 1'b0;
      flevel_q    <= 1'b0;
      fpress_q    <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pending_q   <= pending_d;
      flevel_q    <= flevel_d;
      fpress_q    <= fpress_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press;
  assign frame_level = flevel_q;
  assign frame_press = fpress_q;
endmodule

module input_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int STEP_IDX        = 3,
  parameter int LEFT_IDX        = 2,
  parameter int RIGHT_IDX       = 1,
  parameter int ATK_IDX         = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic              frame_tick,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] frame_level,
  output logic [N_KEYS-1:0] frame_press,
  output logic              move_left,
  output logic              move_right,
  output logic              attack,
  output logic              step_pulse
);
  input_conditioner_lane #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_lane [N_KEYS-1:0] (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .frame_tick (frame_tick),
    .key_level  (key_level),
    .key_press  (key_press),
    .frame_level(frame_level),
    .frame_press(frame_press)
  );

  // Opposing directions held together cancel out.
  assign move_left  = frame_level[LEFT_IDX] & ~frame_level[RIGHT_IDX];
  assign move_right = frame_level[RIGHT_IDX] & ~frame_level[LEFT_IDX];
  assign attack     = frame_press[ATK_IDX];
  assign step_pulse = key_press[STEP_IDX];
endmodule
